// File: rtl/test_result_reporter_pkg.sv
// Shared types and constants for the riscv-tests result reporter.
// REPORTER_X27_ECHO_EN appends the x27 value to the fail report.
package test_result_reporter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_F  = 8'h46;
  localparam logic [7:0] CH_I  = 8'h49;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_X  = 8'h78;
  localparam logic [7:0] CH_2  = 8'h32;
  localparam logic [7:0] CH_7  = 8'h37;
  localparam logic [7:0] CH_EQ = 8'h3D;

  localparam logic [4:0] REG_X3  = 5'd3;
  localparam logic [4:0] REG_X26 = 5'd26;
  localparam logic [4:0] REG_X27 = 5'd27;

  localparam logic [4:0] PASS_LEN = 5'd6;
`ifdef REPORTER_X27_ECHO_EN
  localparam logic [4:0] FAIL_LEN = 5'd30;
`else
  localparam logic [4:0] FAIL_LEN = 5'd9;
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/test_result_reporter_uart_tx.sv
// 8N1 byte transmitter; ready goes high in the last stop-bit cycle
// so a new byte can be chained with no idle gap.
module uart_tx_byte #(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  logic        active;
  logic [3:0]  bit_idx;
  logic [15:0] div_cnt;
  logic [8:0]  shreg;
  logic        bit_end;

  assign bit_end = (div_cnt == DIV_M1);
  assign ready   = !active || (bit_end && bit_idx == 4'd9);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active  <= 1'b0;
      bit_idx <= '0;
      div_cnt <= '0;
      shreg   <= '1;
      tx      <= 1'b1;
    end else if (start && ready) begin
      active  <= 1'b1;
      bit_idx <= '0;
      div_cnt <= '0;
      shreg   <= {1'b1, data};
      tx      <= 1'b0;
    end else if (active) begin
      if (!bit_end) begin
        div_cnt <= div_cnt + 16'd1;
      end else begin
        div_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end
    end
  end

endmodule

// File: rtl/test_result_reporter.sv
// Snoops regfile writes for the riscv-tests x26/x27/x3 protocol and
// reports the verdict over UART. REPORTER_X27_ECHO_EN adds x27 echo.
module test_result_reporter
  import test_result_reporter_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int DRAIN_CYCLES = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            tx,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      fail_num
);

  localparam int DIV =
    (CLK_FREQ / BAUD > 1) ? CLK_FREQ / BAUD : 1;
  localparam logic [31:0] DRAIN_INIT = 32'(DRAIN_CYCLES - 1);

  state_t      state, state_nx;
  logic [31:0] drain_cnt;
  logic [4:0]  idx;
  logic [4:0]  msg_len;
  logic [7:0]  x3_lo;
  logic        x27_one;
  logic        trig, wr_x3, wr_x27;
  logic        verdict, start, uart_rdy;
  logic [7:0]  byte_sel;

`ifdef REPORTER_X27_ECHO_EN
  logic [63:0] x27_sh, x27_lat, nib_vec;
  logic [4:0]  nib_pos;
`endif

  assign wr_x3   = wb_we && wb_rd == REG_X3;
  assign wr_x27  = wb_we && wb_rd == REG_X27;
  assign trig    = wb_we && wb_rd == REG_X26
                && wb_data == XLEN'(1);
  assign verdict = state == S_DRAIN && drain_cnt == '0;
  assign msg_len = pass ? PASS_LEN : FAIL_LEN;
  assign start   = state == S_SEND && idx < msg_len && uart_rdy;
  assign busy    = state == S_DRAIN || state == S_SEND;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (trig) state_nx = S_DRAIN;
      S_DRAIN: if (drain_cnt == '0) state_nx = S_SEND;
      S_SEND:  if (idx == msg_len && uart_rdy) state_nx = S_DONE;
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      idx       <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_num  <= '0;
      x3_lo     <= '0;
      x27_one   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && trig)
        drain_cnt <= DRAIN_INIT;
      else if (state == S_DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 32'd1;
      // verdict samples the shadows before this edge's writes land
      if (verdict) begin
        done     <= 1'b1;
        pass     <= x27_one;
        fail_num <= x3_lo;
      end
      if (start)
        idx <= idx + 5'd1;
      if (wr_x3)
        x3_lo <= wb_data[7:0];
      if (wr_x27)
        x27_one <= wb_data == XLEN'(1);
    end
  end

`ifdef REPORTER_X27_ECHO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x27_sh  <= '0;
      x27_lat <= '0;
    end else begin
      if (verdict)
        x27_lat <= x27_sh;
      if (wr_x27)
        x27_sh <= 64'(wb_data);
    end
  end

  assign nib_pos = 5'd27 - idx;
  assign nib_vec = x27_lat >> {nib_pos[3:0], 2'b00};
`endif

  always_comb begin
    byte_sel = CH_CR;
    if (pass) begin
      case (idx)
        5'd0:    byte_sel = CH_P;
        5'd1:    byte_sel = CH_A;
        5'd2:    byte_sel = CH_S;
        5'd3:    byte_sel = CH_S;
        5'd4:    byte_sel = CH_CR;
        default: byte_sel = CH_LF;
      endcase
    end else begin
      case (idx)
        5'd0:    byte_sel = CH_F;
        5'd1:    byte_sel = CH_A;
        5'd2:    byte_sel = CH_I;
        5'd3:    byte_sel = CH_L;
        5'd4:    byte_sel = CH_SP;
        5'd5:    byte_sel = hex_char(fail_num[7:4]);
        5'd6:    byte_sel = hex_char(fail_num[3:0]);
`ifdef REPORTER_X27_ECHO_EN
        5'd7:    byte_sel = CH_SP;
        5'd8:    byte_sel = CH_X;
        5'd9:    byte_sel = CH_2;
        5'd10:   byte_sel = CH_7;
        5'd11:   byte_sel = CH_EQ;
        5'd28:   byte_sel = CH_CR;
        5'd29:   byte_sel = CH_LF;
        default: byte_sel = hex_char(nib_vec[3:0]);
`else
        5'd7:    byte_sel = CH_CR;
        default: byte_sel = CH_LF;
`endif
      endcase
    end
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (byte_sel),
    .tx   (tx),
    .ready(uart_rdy)
  );

endmodule
